gate_checker: RTL and testbench
===============================

GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning extra cycles each vector is held before sampling (range 0..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  begin a check run; sampled only in IDLE.
REQ-005 SHALL have port func_sel  input  2  expected gate function: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-006 SHALL have port gate_a  output  1  stimulus to gate-under-test input a.
REQ-007 SHALL have port gate_b  output  1  stimulus to gate-under-test input b.
REQ-008 SHALL have port gate_y  input  1  gate-under-test output, treated as combinational from gate_a/gate_b.
REQ-009 SHALL have port busy  output  1  run in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-011 SHALL have port pass  output  1  last run had zero mismatches.
REQ-012 SHALL have port err_mask  output  4  bit k set when vector k mismatched.
REQ-013 SHALL have port err_count  output  3  number of mismatched vectors, 0..4.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, REPORT.
REQ-015 IDLE: gate_a=gate_b=0, busy=0; on start=1 at edge E0 SHALL go to APPLY, latch func_sel, clear err_mask/err_count/pass, drive vector 0, set busy=1.
REQ-016 Vector k (k=0..3) SHALL drive gate_a=k[1], gate_b=k[0], i.e. order 00, 01, 10, 11.
REQ-017 Vector k SHALL be driven from edge E0+k*(SETTLE_CYCLES+1); gate_y SHALL be sampled at edge E0+(k+1)*(SETTLE_CYCLES+1).
REQ-018 At each sample edge, mismatch (gate_y != expected(latched func, a, b)) SHALL set err_mask[k] and increment err_count.
REQ-019 At the vector-3 sample edge SHALL go to REPORT: busy=0, done=1 for exactly one cycle, pass=1 iff final err_count==0, gate_a=gate_b=0.
REQ-020 REPORT SHALL return to IDLE after one cycle; start during REPORT SHALL be ignored.
REQ-021 start during APPLY SHALL be ignored; func_sel changes during a run SHALL not affect it.
REQ-022 pass, err_mask, err_count SHALL hold their values from REPORT until the next accepted start.
REQ-023 Run length SHALL be 4*(SETTLE_CYCLES+1) cycles from E0 to done; SETTLE_CYCLES=0 samples every cycle.
REQ-024 Vector counter wrap 3->0 SHALL not occur within a run; the run ends at 3.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE and zero gate_a, gate_b, busy, done, pass, err_mask, err_count, counters.
REQ-026 rst mid-run SHALL abort with no done pulse; rst overrides start in the same cycle.

Structure
REQ-027 Package gate_check_pkg SHALL hold func_sel codes, FSM state encoding, and SETTLE counter width constant.
REQ-028 Expected-value logic SHALL be sub-module gate_ref_model (inputs func, a, b; output y_exp), purely combinational.

Verification
REQ-029 AND gate DUT, func_sel=00, SETTLE_CYCLES=1, start pulse -> done high 8 cycles after E0, pass=1, err_mask=0000, err_count=0.
REQ-030 AND gate DUT, func_sel=01 (OR) -> err_mask=0110, err_count=2, pass=0.
REQ-031 gate_y tied 1, func_sel=10 (XOR) -> err_mask=1001, err_count=2, pass=0.
REQ-032 gate_y tied 0, func_sel=00 -> err_mask=1000, err_count=1; re-run with correct AND DUT -> pass=1, err_mask=0000.
REQ-033 start re-pulsed and func_sel toggled mid-run -> run unaffected, single done pulse at expected cycle.
REQ-034 rst asserted at cycle 3 of a run -> next cycle all outputs 0, no done pulse, new start runs normally.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate checker: gate function codes, FSM encoding
// and the width of the per-vector settle counter.
package gate_check_pkg;

  typedef enum logic [1:0] {
    FUNC_AND  = 2'b00,
    FUNC_OR   = 2'b01,
    FUNC_XOR  = 2'b10,
    FUNC_NAND = 2'b11
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  // Settle counter must hold SETTLE_CYCLES up to 15.
  localparam int SETTLE_W = 4;
  localparam logic [1:0] LAST_VEC = 2'd3;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model: the value a correct gate of the selected
// function produces for inputs a and b.
module gate_ref_model
  import gate_check_pkg::*;
(
  input  logic [1:0] func,
  input  logic       a,
  input  logic       b,
  output logic       y_exp
);

  always_comb begin
    unique case (func_e'(func))
      FUNC_AND:  y_exp = a & b;
      FUNC_OR:   y_exp = a | b;
      FUNC_XOR:  y_exp = a ^ b;
      FUNC_NAND: y_exp = ~(a & b);
      default:   y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_checker.sv
// Exhaustive 2-input gate tester: walks vectors 00,01,10,11, holds each for
// SETTLE_CYCLES+1 cycles, compares gate_y against the reference, reports.
module gate_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] func_sel,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask,
  output logic [2:0] err_count
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);

  state_e              state_q, state_d;
  logic [1:0]          func_q, func_d;
  logic [1:0]          vec_q, vec_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [3:0]          err_mask_q, err_mask_d;
  logic [2:0]          err_count_q, err_count_d;
  logic                pass_q, pass_d;

  logic y_exp;
  logic sample;
  logic mismatch;

  gate_ref_model u_ref (
    .func  (func_q),
    .a     (gate_a),
    .b     (gate_b),
    .y_exp (y_exp)
  );

  // gate_y is sampled on the last settle cycle of the current vector.
  assign sample   = (state_q == ST_APPLY) && (cnt_q == SETTLE_LAST);
  assign mismatch = (gate_y != y_exp);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      func_q      <= 2'b00;
      vec_q       <= 2'd0;
      cnt_q       <= '0;
      err_mask_q  <= 4'b0000;
      err_count_q <= 3'd0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      func_q      <= func_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      err_mask_q  <= err_mask_d;
      err_count_q <= err_count_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_APPLY;
      ST_APPLY:  if (sample && (vec_q == LAST_VEC)) state_d = ST_REPORT;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: every signal written here gets its hold value first, so no path
  // through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    func_d      = func_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    err_mask_d  = err_mask_q;
    err_count_d = err_count_q;
    pass_d      = pass_q;
    if ((state_q == ST_IDLE) && start) begin
      func_d      = func_sel;
      vec_d       = 2'd0;
      cnt_d       = '0;
      err_mask_d  = 4'b0000;
      err_count_d = 3'd0;
      pass_d      = 1'b0;
    end else if (state_q == ST_APPLY) begin
      if (sample) begin
        cnt_d = '0;
        if (mismatch) begin
          err_mask_d[vec_q] = 1'b1;
          err_count_d       = err_count_q + 3'd1;
        end
        if (vec_q == LAST_VEC) pass_d = (err_count_d == 3'd0);
        else                   vec_d  = vec_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    gate_a = 1'b0;
    gate_b = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (state_q)
      ST_APPLY: begin
        gate_a = vec_q[1];
        gate_b = vec_q[0];
        busy   = 1'b1;
      end
      ST_REPORT: done = 1'b1;
      default: ;
    endcase
  end

  assign pass      = pass_q;
  assign err_mask  = err_mask_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_checker.sv
// Self-checking bench for gate_checker: a behavioural gate-under-test drives
// gate_y, expected run results are queued at start and compared at done.
module tb_gate_checker;

  localparam int unsigned S = 1;
  localparam int RUN_LEN = 4 * (S + 1);

  typedef struct {
    logic [3:0] mask;
    logic [2:0] count;
    logic       pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] func_sel;
  logic       gate_a, gate_b, gate_y;
  logic       busy, done, pass;
  logic [3:0] err_mask;
  logic [2:0] err_count;

  int   gut_mode;  // 0: real AND gate, 1: output stuck high, 2: stuck low
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  gate_checker #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .func_sel  (func_sel),
    .gate_a    (gate_a),
    .gate_b    (gate_b),
    .gate_y    (gate_y),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_mask  (err_mask),
    .err_count (err_count)
  );

  function automatic logic gut_y(input int mode, input logic a, input logic b);
    case (mode)
      1:       return 1'b1;
      2:       return 1'b0;
      default: return a & b;
    endcase
  endfunction

  function automatic logic exp_fn(input logic [1:0] f, input logic a, input logic b);
    case (f)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  assign gate_y = gut_y(gut_mode, gate_a, gate_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_expected(input logic [1:0] f, input int mode);
    exp_t e;
    logic [1:0] kv;
    e.mask  = 4'b0000;
    e.count = 3'd0;
    for (int k = 0; k < 4; k++) begin
      kv = 2'(k);
      if (gut_y(mode, kv[1], kv[0]) != exp_fn(f, kv[1], kv[0])) begin
        e.mask[k] = 1'b1;
        e.count   = e.count + 3'd1;
      end
    end
    e.pass = (e.count == 3'd0);
    sb_q.push_back(e);
  endtask

  // Starts a run at the next edge (E0) and follows it to completion; with
  // disturb set, start/func_sel are wiggled mid-run and start is held in REPORT.
  task automatic run_check(input string name, input logic [1:0] f, input int mode,
                           input bit disturb);
    exp_t e;
    int n;
    bit seen;
    logic [1:0] kv;
    gut_mode = mode;
    func_sel = f;
    start    = 1'b1;
    push_expected(f, mode);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (n = 0; n < RUN_LEN + 4; n++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      check({name, ".busy"}, busy, 1);
      if (n < RUN_LEN) begin
        kv = 2'(n / (S + 1));
        check({name, ".vec"}, {gate_a, gate_b}, kv);
      end
      if (disturb && n == 2) begin
        start    = 1'b1;
        func_sel = ~f;
      end
      if (disturb && n == 3) start = 1'b0;
      @(negedge clk);
    end
    check({name, ".done_seen"}, seen, 1);
    check({name, ".latency"}, n, RUN_LEN);
    if (sb_q.size() == 0) begin
      check({name, ".sb_empty"}, 0, 1);
      return;
    end
    e = sb_q.pop_front();
    if (seen) begin
      check({name, ".err_mask"}, err_mask, e.mask);
      check({name, ".err_count"}, err_count, e.count);
      check({name, ".pass"}, pass, e.pass);
      check({name, ".report_idle"}, {busy, gate_a, gate_b}, 3'b000);
    end
    if (disturb) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, ".done_1cyc"}, {done, busy}, 2'b00);
    @(negedge clk);
    check({name, ".idle_busy"}, busy, 0);
    check({name, ".held"}, {pass, err_mask, err_count}, {e.pass, e.mask, e.count});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    func_sel = 2'b00;
    gut_mode = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {gate_a, gate_b, busy, done, pass, err_mask, err_count}, 12'h000);
    rst = 1'b0;
    @(negedge clk);

    run_check("and_ok",      2'b00, 0, 1'b0);
    run_check("and_as_or",   2'b01, 0, 1'b0);
    run_check("hi_as_xor",   2'b10, 1, 1'b0);
    run_check("lo_as_and",   2'b00, 2, 1'b0);
    run_check("and_rerun",   2'b00, 0, 1'b0);
    run_check("and_as_nand", 2'b11, 0, 1'b0);
    run_check("disturbed",   2'b10, 0, 1'b1);

    // Abort a run with reset at the third edge after E0.
    gut_mode = 0;
    func_sel = 2'b00;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {gate_a, gate_b, busy, done, pass, err_mask, err_count}, 12'h000);
    rst = 1'b0;
    for (int i = 0; i < RUN_LEN + 2; i++) begin
      check("abort_no_done", done, 0);
      @(negedge clk);
    end

    // Reset wins over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("rst_over_start", busy, 0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);

    run_check("after_abort", 2'b00, 0, 1'b0);
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
